// File: rtl/booth_mult_seq_if.sv
// Start/operand/result bundle between the multdiv control and the Booth multiplier.
//   master: ctrl_MULT, data_operandA, data_operandB (out); data_result,
//           data_exception, data_resultRDY, busy (in)
//   slave : the mirror image, used by booth_mult_seq
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
//   clk        : rising-edge clock
//   ctrl_reset : asynchronous active-high reset
//   bus        : slave side of booth_mult_seq_if
//                ctrl_MULT starts (or restarts) an operation, operands sampled same edge
//                data_result/data_exception registered, held until the next completion
//                data_resultRDY one-cycle pulse in DONE, busy high in RUN
module booth_mult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         ctrl_reset,
    booth_mult_seq_if.slave bus
);
    localparam int unsigned HW = WIDTH + 1;          // high half incl. guard bit
    localparam int unsigned PW = 2 * WIDTH + 2;      // guard + hi + B + Booth bit
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [HW-1:0]    m;
    logic [PW-1:0]    p;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;
    logic             exc;

    logic [HW-1:0]    hi;
    logic [HW-1:0]    hi_sum;
    logic [PW-1:0]    p_step;
    logic             step_exc;

    // One Booth step: add/sub multiplicand into the high half, then arithmetic shift.
    always_comb begin
        hi = p[PW-1:WIDTH+1];
        case (p[1:0])
            2'b01:   hi_sum = hi + m;
            2'b10:   hi_sum = hi - m;
            default: hi_sum = hi;
        endcase
        p_step   = {hi_sum[HW-1], hi_sum, p[WIDTH:1]};
        // Product fits iff everything above the result's sign bit replicates it.
        step_exc = (p_step[PW-1:WIDTH+1] != {HW{p_step[WIDTH]}});
    end

    // Control, datapath and result registers.
    always_ff @(posedge clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state  <= IDLE;
            m      <= '0;
            p      <= '0;
            count  <= '0;
            result <= '0;
            exc    <= 1'b0;
        end else if (bus.ctrl_MULT) begin
            // Start wins in every state; an in-flight operation is silently dropped.
            m     <= {bus.data_operandA[WIDTH-1], bus.data_operandA};
            p     <= {HW'(0), bus.data_operandB, 1'b0};
            count <= '0;
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    p     <= p_step;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state  <= DONE;
                        result <= p_step[WIDTH:1];
                        exc    <= step_exc;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corners, restart/reset cases and
// random operands against a plain signed-arithmetic reference.
module tb_booth_mult_seq;
    localparam int unsigned WIDTH = 32;
    localparam int WINDOW = WIDTH + 6;

    logic clk = 1'b0;
    logic ctrl_reset;
    int   checks = 0;
    int   errors = 0;

    booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

    booth_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed product, low WIDTH bits, overflow if it doesn't fit.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] res, output logic ex);
        longint prod;
        longint sx;
        prod = longint'($signed(a)) * longint'($signed(b));
        res  = prod[WIDTH-1:0];
        sx   = longint'($signed(res));
        ex   = (sx != prod);
    endtask

    // Drive a start pulse on the next edge; operands are scrambled afterwards.
    task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = 1'b1;
        @(posedge clk);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Watch a bounded number of edges; report first RDY edge index and pulse count.
    task automatic watch(input int edges, output int first, output int n);
        first = 0;
        n     = 0;
        for (int e = 1; e <= edges; e++) begin
            @(posedge clk);
            #1;
            if (bus.data_resultRDY === 1'b1) begin
                n++;
                if (first == 0) first = e;
            end
        end
    endtask

    task automatic do_mult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        logic ex;
        int first, n;
        model(a, b, res, ex);
        start(a, b);
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        watch(WINDOW, first, n);
        check({tag, "_rdy_count"}, 64'(n), 64'd1);
        check({tag, "_rdy_edge"}, 64'(first), 64'(WIDTH));
        check({tag, "_result"}, 64'(bus.data_result), 64'(res));
        check({tag, "_exc"}, 64'(bus.data_exception), 64'(ex));
    endtask

    initial begin
        int first, n;
        logic [WIDTH-1:0] res, prev_res;
        logic ex;

        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        ctrl_reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exc", 64'(bus.data_exception), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        ctrl_reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed corners.
        do_mult("m6x7", 32'd6, 32'd7);
        check("m6x7_rdy_gone", 64'(bus.data_resultRDY), 64'd0);
        do_mult("m_neg5x3", 32'hFFFF_FFFB, 32'd3);
        check("m_neg5x3_abs", 64'(bus.data_result), 64'hFFFF_FFF1);
        do_mult("m0xmin", 32'd0, 32'h8000_0000);
        do_mult("mmaxx2", 32'h7FFF_FFFF, 32'd2);
        check("mmaxx2_abs_exc", 64'(bus.data_exception), 64'd1);
        do_mult("mminx1", 32'h8000_0000, 32'd1);
        do_mult("mminxneg1", 32'h8000_0000, 32'hFFFF_FFFF);
        check("mminxneg1_abs", 64'(bus.data_result), 64'h8000_0000);
        check("mminxneg1_abs_exc", 64'(bus.data_exception), 64'd1);
        do_mult("mminxmin", 32'h8000_0000, 32'h8000_0000);

        // Restart mid-RUN: only the second operation completes.
        prev_res = bus.data_result;
        start(32'd3, 32'd4);
        watch(9, first, n);
        check("restart_no_rdy_early", 64'(n), 64'd0);
        start(32'd5, 32'd5);
        check("restart_hold_result", 64'(bus.data_result), 64'(prev_res));
        watch(WINDOW, first, n);
        check("restart_rdy_count", 64'(n), 64'd1);
        check("restart_rdy_edge", 64'(first), 64'(WIDTH));
        check("restart_result", 64'(bus.data_result), 64'd25);

        // Start during DONE: old op's RDY already shown, new op follows.
        start(32'd6, 32'd7);
        watch(WIDTH, first, n);
        check("done_restart_rdy", 64'(bus.data_resultRDY), 64'd1);
        check("done_restart_res1", 64'(bus.data_result), 64'd42);
        start(32'd11, 32'd13);
        check("done_restart_rdy_low", 64'(bus.data_resultRDY), 64'd0);
        check("done_restart_busy", 64'(bus.busy), 64'd1);
        watch(WINDOW, first, n);
        check("done_restart_rdy_edge", 64'(first), 64'(WIDTH));
        check("done_restart_res2", 64'(bus.data_result), 64'd143);

        // Async reset mid-RUN discards the operation.
        start(32'd9, 32'd9);
        repeat (14) @(posedge clk);
        #2;
        ctrl_reset = 1'b1;
        #1;
        check("midrst_result", 64'(bus.data_result), 64'd0);
        check("midrst_exc", 64'(bus.data_exception), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_rdy", 64'(bus.data_resultRDY), 64'd0);
        @(posedge clk);
        #1;
        ctrl_reset = 1'b0;
        watch(WINDOW, first, n);
        check("midrst_no_rdy", 64'(n), 64'd0);
        check("midrst_result_after", 64'(bus.data_result), 64'd0);
        do_mult("after_rst_2x3", 32'd2, 32'd3);

        // Random operands, mixing full-range and small values.
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) a = WIDTH'($signed($urandom_range(0, 2000)) - 1000);
            if (i % 4 == 2) b = WIDTH'($signed($urandom_range(0, 2000)) - 1000);
            do_mult($sformatf("rnd%0d", i), a, b);
        end

        model(32'd1, 32'd1, res, ex);
        do_mult("m1x1", 32'd1, 32'd1);
        check("m1x1_abs", 64'(bus.data_result), 64'(res));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog: report and stop rather than hang.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
